gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable response checker for 2-input logic gates: accepts (a, b, y) samples over a valid/ready handshake, compares y against the expected truth-table value for a selected gate function, and accumulates sample, error and vector-coverage results. It sits on the far end of a gate-under-test and consumes its stimulus/response pairs. This lets the directed gate sweeps the team runs in simulation also be checked in hardware.

## Interface
- CNT_W, 8, width of sample and error counters (saturating)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a check run
- op  input  3  gate function, sampled on start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 reserved
- in_valid  input  1  sample present on a/b/y
- in_ready  output  1  checker accepts a sample this cycle
- a, b  input  1 each  stimulus applied to gate-under-test
- y  input  1  observed gate output
- busy  output  1  run in progress
- done  output  1  run complete; held until the next start
- pass  output  1  valid while done: err_cnt == 0
- smp_cnt  output  CNT_W  accepted samples
- err_cnt  output  CNT_W  mismatching samples
- cov  output  4  bit {a,b} set once that input vector has been seen
- first_err_vec  output  2  {a,b} of the first mismatch
- first_err_valid  output  1  first_err_vec holds a captured mismatch

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start: latch op, clear smp_cnt, err_cnt, cov, first_err_*, then go to RUN.
- RUN: start is ignored. in_ready = 1. A sample is accepted when in_valid && in_ready.
- On accept:
  - smp_cnt += 1, saturating at 2^CNT_W−1.
  - exp = f_op(a,b). If y != exp, err_cnt += 1, saturating.
  - cov[{a,b}] set.
  - First mismatch of the run loads first_err_vec = {a,b} and first_err_valid = 1. Later mismatches do not overwrite it.
- Reserved op (6–7): exp = ~y, so every accepted sample counts as a mismatch and pass = 0.
- RUN → DONE on the cycle after the accept that makes cov == 4'hF. Repeated vectors before that are all checked and counted.
- DONE: results hold, in_ready = 0, pass = (err_cnt == 0).
- in_valid while not in RUN: no effect.
- Reset values: state IDLE; in_ready, busy, done, pass = 0; smp_cnt, err_cnt = 0; cov = 0; first_err_vec = 0; first_err_valid = 0.
- rst mid-run: all state returns to reset values on that edge, and the run's partial results are discarded.

## Timing
- start at edge N → busy = 1 and in_ready = 1 from N+1.
- Sample accepted at edge M → counters, cov and first_err_* updated after edge M, visible in cycle M+1.
- Completing accept at edge M → done = 1, busy = 0, in_ready = 0 in cycle M+1. No further sample is accepted after the completing one.
- Counter saturation: the counter holds its maximum and the run continues normally.
- start and in_valid in the same IDLE/DONE cycle: start wins and the sample is not accepted.

## Configuration
- GATE_CHK_FIRST_ERR_EN defined: first-error capture logic is built as described.
- Undefined: no capture registers are built. first_err_vec = 0 and first_err_valid = 0 constantly. All other behaviour is identical.

## Structure
- Package gate_chk_pkg holds:
  - op encoding localparams (OP_AND … OP_XNOR)
  - state typedef (IDLE/RUN/DONE)
  - default CNT_W constant
- One combinational sub-module, gate_ref (op, a, b → exp), holds the truth table so it can be reused by other checkers.

## Test plan
- op=0 (AND), feed a correct AND gate vectors 00,01,10,11 back-to-back → done one cycle after the 4th accept; smp_cnt=4, err_cnt=0, cov=4'hF, pass=1.
- op=2 (XOR) with the DUT actually an AND → mismatch on 01,10,11; err_cnt=3, pass=0, first_err_vec=2'b01, first_err_valid=1 (macro on), or 0 (macro off).
- op=1 (OR), vectors 00,00,01,01,10,11 with in_valid gaps → smp_cnt=6, done only after 11, in_ready=0 afterwards; extra in_valid ignored.
- CNT_W=2, op=0, 5×00 with y forced to 1, then 01,10,11 correct → err_cnt saturates at 3, smp_cnt=3, pass=0.
- rst asserted after 2 accepts → all outputs return to reset values next cycle; a new start gives a fresh run with smp_cnt starting from 0.
- op=7 → every sample is an error; start pulsed during RUN is ignored; start in DONE restarts a run with cleared results.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the 2-input gate response checker: op encoding,
// FSM state encoding and the default counter width.
package gate_chk_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    // Gate function encoding; 6 and 7 are reserved.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op > OP_XNOR;
    endfunction

endpackage

// File: rtl/gate_ref.sv
// Combinational truth-table reference for 2-input gates.
// Reserved ops yield 0; callers must detect reserved ops themselves.
module gate_ref
    import gate_chk_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       exp
);

    // Expected gate output for the selected function
    always_comb begin
        exp = 1'b0;
        case (op)
            OP_AND:  exp = a & b;
            OP_OR:   exp = a | b;
            OP_XOR:  exp = a ^ b;
            OP_NAND: exp = ~(a & b);
            OP_NOR:  exp = ~(a | b);
            OP_XNOR: exp = ~(a ^ b);
            default: exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate under test. Consumes (a, b, y) samples
// over valid/ready, compares y with the reference truth table, and tracks
// sample/error counts (saturating) plus input-vector coverage. A run ends
// once all four input vectors have been seen.
// Optional: define GATE_CHK_FIRST_ERR_EN to build first-mismatch capture.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [1:0]       first_err_vec,
    output logic             first_err_valid
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       cov_q, cov_d;

    logic       run_start;
    logic       accept;
    logic       exp;
    logic       mismatch;
    logic [3:0] cov_set;

    gate_ref u_gate_ref (
        .op  (op_q),
        .a   (a),
        .b   (b),
        .exp (exp)
    );

    // start is only honoured outside a run; it takes priority over a sample
    assign run_start = start && (state_q != ST_RUN);
    assign accept    = in_valid && (state_q == ST_RUN);
    // Reserved ops behave as exp = ~y, i.e. every sample mismatches
    assign mismatch  = op_is_reserved(op_q) ? 1'b1 : (y != exp);
    assign cov_set   = cov_q | (4'b0001 << {a, b});

    // Next-state for FSM, latched op, counters and coverage
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        smp_cnt_d = smp_cnt_q;
        err_cnt_d = err_cnt_q;
        cov_d     = cov_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run_start) begin
                    state_d   = ST_RUN;
                    op_d      = op;
                    smp_cnt_d = '0;
                    err_cnt_d = '0;
                    cov_d     = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (smp_cnt_q != '1) smp_cnt_d = smp_cnt_q + CNT_W'(1);
                    if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
                    cov_d = cov_set;
                    if (cov_set == 4'hF) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_AND;
            smp_cnt_q <= '0;
            err_cnt_q <= '0;
            cov_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            smp_cnt_q <= smp_cnt_d;
            err_cnt_q <= err_cnt_d;
            cov_q     <= cov_d;
        end
    end

`ifdef GATE_CHK_FIRST_ERR_EN
    logic [1:0] first_err_vec_q, first_err_vec_d;
    logic       first_err_valid_q, first_err_valid_d;

    // Capture the first mismatching vector of a run; later ones are ignored
    always_comb begin
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        if (run_start) begin
            first_err_vec_d   = 2'b00;
            first_err_valid_d = 1'b0;
        end else if (accept && mismatch && !first_err_valid_q) begin
            first_err_vec_d   = {a, b};
            first_err_valid_d = 1'b1;
        end
    end

    // First-error capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_vec_q   <= 2'b00;
            first_err_valid_q <= 1'b0;
        end else begin
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;
`else
    assign first_err_vec   = 2'b00;
    assign first_err_valid = 1'b0;
`endif

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = (state_q == ST_DONE) && (err_cnt_q == '0);
    assign smp_cnt  = smp_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign cov      = cov_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: one instance at default width,
// one at CNT_W=2 for saturation. Inputs change 1 time unit after the rising
// edge; outputs are checked at that same point, after the edge has settled.
module tb_gate_response_checker;

`ifdef GATE_CHK_FIRST_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start8;
    logic       start2;
    logic [2:0] op;
    logic       in_valid;
    logic       a, b, y;

    logic       rdy8, busy8, done8, pass8, fev8;
    logic [7:0] smp8, err8;
    logic [3:0] cov8;
    logic [1:0] fe8;

    logic       rdy2, busy2, done2, pass2, fev2;
    logic [1:0] smp2, err2;
    logic [3:0] cov2;
    logic [1:0] fe2;

    int n_checks;
    int n_fail;

    gate_response_checker #(.CNT_W(8)) u_dut8 (
        .clk             (clk),
        .rst             (rst),
        .start           (start8),
        .op              (op),
        .in_valid        (in_valid),
        .in_ready        (rdy8),
        .a               (a),
        .b               (b),
        .y               (y),
        .busy            (busy8),
        .done            (done8),
        .pass            (pass8),
        .smp_cnt         (smp8),
        .err_cnt         (err8),
        .cov             (cov8),
        .first_err_vec   (fe8),
        .first_err_valid (fev8)
    );

    gate_response_checker #(.CNT_W(2)) u_dut2 (
        .clk             (clk),
        .rst             (rst),
        .start           (start2),
        .op              (op),
        .in_valid        (in_valid),
        .in_ready        (rdy2),
        .a               (a),
        .b               (b),
        .y               (y),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .smp_cnt         (smp2),
        .err_cnt         (err2),
        .cov             (cov2),
        .first_err_vec   (fe2),
        .first_err_valid (fev2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic va, input logic vb, input logic vy);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        y        = vy;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_dut8(input logic [2:0] o);
        op     = o;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic check_reset8(input string tag);
        check_eq({tag, " in_ready"}, rdy8, 0);
        check_eq({tag, " busy"}, busy8, 0);
        check_eq({tag, " done"}, done8, 0);
        check_eq({tag, " pass"}, pass8, 0);
        check_eq({tag, " smp_cnt"}, smp8, 0);
        check_eq({tag, " err_cnt"}, err8, 0);
        check_eq({tag, " cov"}, cov8, 0);
        check_eq({tag, " fe_vec"}, fe8, 0);
        check_eq({tag, " fe_valid"}, fev8, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start8   = 1'b0;
        start2   = 1'b0;
        op       = 3'd0;
        in_valid = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        y        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset8("rst");
        check_eq("rst dut2 smp", smp2, 0);

        // AND, correct gate, back-to-back
        start_dut8(3'd0);
        check_eq("and busy", busy8, 1);
        check_eq("and in_ready", rdy8, 1);
        send(0, 0, 0);
        send(0, 1, 0);
        send(1, 0, 0);
        check_eq("and cov3", cov8, 4'b0111);
        check_eq("and done early", done8, 0);
        send(1, 1, 1);
        check_eq("and done", done8, 1);
        check_eq("and busy end", busy8, 0);
        check_eq("and in_ready end", rdy8, 0);
        check_eq("and smp", smp8, 4);
        check_eq("and err", err8, 0);
        check_eq("and cov", cov8, 4'hF);
        check_eq("and pass", pass8, 1);

        // XOR expected, AND gate observed
        start_dut8(3'd2);
        check_eq("xor cleared smp", smp8, 0);
        send(0, 0, 0);
        send(0, 1, 0);
        send(1, 0, 0);
        send(1, 1, 1);
        check_eq("xor done", done8, 1);
        check_eq("xor err", err8, 3);
        check_eq("xor pass", pass8, 0);
        check_eq("xor fe_vec", fe8, FE_EN ? 2'b01 : 2'b00);
        check_eq("xor fe_valid", fev8, FE_EN ? 1 : 0);

        // OR with repeats and valid gaps
        start_dut8(3'd1);
        send(0, 0, 0);
        tick();
        send(0, 0, 0);
        send(0, 1, 1);
        tick();
        tick();
        send(0, 1, 1);
        send(1, 0, 1);
        check_eq("or not done", done8, 0);
        check_eq("or cov", cov8, 4'b0111);
        tick();
        send(1, 1, 1);
        check_eq("or smp", smp8, 6);
        check_eq("or done", done8, 1);
        check_eq("or in_ready", rdy8, 0);
        send(0, 0, 1);
        check_eq("or extra ignored smp", smp8, 6);
        check_eq("or extra ignored err", err8, 0);
        check_eq("or pass", pass8, 1);

        // Saturation with CNT_W=2
        op     = 3'd0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) send(0, 0, 1);
        check_eq("sat err mid", err2, 3);
        check_eq("sat busy mid", busy2, 1);
        send(0, 1, 0);
        send(1, 0, 0);
        send(1, 1, 1);
        check_eq("sat done", done2, 1);
        check_eq("sat err", err2, 3);
        check_eq("sat smp", smp2, 3);
        check_eq("sat pass", pass2, 0);
        check_eq("sat fe_vec", fe2, 2'b00);
        check_eq("sat fe_valid", fev2, FE_EN ? 1 : 0);
        check_eq("sat dut8 untouched", smp8, 6);

        // Reset mid-run after two accepts (one mismatch)
        start_dut8(3'd0);
        send(0, 0, 0);
        send(0, 1, 1);
        check_eq("mid smp", smp8, 2);
        check_eq("mid fe_valid", fev8, FE_EN ? 1 : 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset8("midrst");
        start_dut8(3'd0);
        check_eq("fresh smp", smp8, 0);
        send(0, 0, 0);
        check_eq("fresh smp1", smp8, 1);
        send(0, 1, 0);
        send(1, 0, 0);
        send(1, 1, 1);
        check_eq("fresh done", done8, 1);
        check_eq("fresh smp4", smp8, 4);
        check_eq("fresh pass", pass8, 1);

        // Reserved op: every sample fails; start ignored in RUN
        start_dut8(3'd7);
        check_eq("rsv cleared smp", smp8, 0);
        check_eq("rsv cleared cov", cov8, 0);
        send(0, 0, 0);
        check_eq("rsv err1", err8, 1);
        op     = 3'd0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check_eq("rsv start ignored busy", busy8, 1);
        check_eq("rsv start ignored smp", smp8, 1);
        check_eq("rsv start ignored err", err8, 1);
        send(0, 1, 0);
        send(1, 0, 0);
        send(1, 1, 1);
        check_eq("rsv done", done8, 1);
        check_eq("rsv err", err8, 4);
        check_eq("rsv pass", pass8, 0);
        check_eq("rsv fe_vec", fe8, 2'b00);
        check_eq("rsv fe_valid", fev8, FE_EN ? 1 : 0);

        // start and in_valid together in DONE: start wins, sample dropped
        op       = 3'd0;
        start8   = 1'b1;
        in_valid = 1'b1;
        a        = 1'b1;
        b        = 1'b1;
        y        = 1'b1;
        tick();
        start8   = 1'b0;
        in_valid = 1'b0;
        check_eq("restart busy", busy8, 1);
        check_eq("restart done", done8, 0);
        check_eq("restart smp", smp8, 0);
        check_eq("restart err", err8, 0);
        check_eq("restart cov", cov8, 0);
        check_eq("restart fe_valid", fev8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
